// File: rtl/rfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rfile_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned NR_DEF   = 2;
    localparam int unsigned NW_DEF   = 2;
    localparam int unsigned REG_ZERO = 0;

    // Low bit index of port 'port' inside a flattened bus of 'width'-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rfile_scoreboard.sv
// Busy scoreboard: per-register pending-writeback bits and a registered busy count.
module rfile_scoreboard
    import rfile_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2**AW-1:0]  clr,
    input  logic              rsv,
    input  logic [AW-1:0]     a_rsv,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       nbusy
);

    localparam int unsigned NREG = 2**AW;
    localparam int unsigned CW   = AW + 1;

    logic [NREG-1:0] busy_nxt;

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            n = n + CW'(v[k]);
        end
        return n;
    endfunction

    // Writeback clears first, then a reserve on the same edge overrides the clear.
    always_comb begin
        busy_nxt = busy & ~clr;
        if (rsv && (a_rsv != AW'(REG_ZERO))) begin
            busy_nxt[a_rsv] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy  <= '0;
            nbusy <= '0;
        end else begin
            busy  <= busy_nxt;
            nbusy <= popcount(busy_nxt);
        end
    end

endmodule

// File: rtl/rfile_mp.sv
// Multi-port register file with busy scoreboard; r0 is hardwired to zero.
// Define RFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned NR = NR_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NR*AW-1:0]   A_R,
    output logic [NR*DW-1:0]   RD,
    output logic [NR-1:0]      BUSY,
    input  logic [NW-1:0]      WE,
    input  logic [NW*AW-1:0]   A_W,
    input  logic [NW*DW-1:0]   WD,
    input  logic               RSV,
    input  logic [AW-1:0]      A_RSV,
    output logic [AW:0]        NBUSY
);

    localparam int unsigned NREG = 2**AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] clr;
    logic [NREG-1:0] busy;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   wa;

    // One-hot busy clears from every accepted write.
    always_comb begin
        clr = '0;
        wa  = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            wa = A_W[slice_lo(j, AW) +: AW];
            if (WE[j] && (wa != AW'(REG_ZERO))) begin
                clr[wa] = 1'b1;
            end
        end
    end

    // Storage; later write ports override earlier ones on address conflict.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (WE[j] && (A_W[slice_lo(j, AW) +: AW] != AW'(REG_ZERO))) begin
                    regs[A_W[slice_lo(j, AW) +: AW]] <= WD[slice_lo(j, DW) +: DW];
                end
            end
        end
    end

    rfile_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (clr),
        .rsv   (RSV),
        .a_rsv (A_RSV),
        .busy  (busy),
        .nbusy (NBUSY)
    );

    // Combinational read ports.
    always_comb begin
        RD   = '0;
        BUSY = '0;
        ra   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            ra = A_R[slice_lo(i, AW) +: AW];
            if (ra != AW'(REG_ZERO)) begin
                RD[slice_lo(i, DW) +: DW] = regs[ra];
                BUSY[i]                   = busy[ra];
`ifdef RFILE_BYPASS_EN
                for (int unsigned j = 0; j < NW; j++) begin
                    if (WE[j] && (A_W[slice_lo(j, AW) +: AW] == ra)) begin
                        RD[slice_lo(i, DW) +: DW] = WD[slice_lo(j, DW) +: DW];
                        BUSY[i]                   = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rfile_mp.sv
// Self-checking bench for rfile_mp: directed checks plus randomized traffic against a model.
module tb_rfile_mp;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NR   = 2;
    localparam int unsigned NW   = 2;
    localparam int unsigned NREG = 32;

    logic              CLK = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  a_r;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     busy_o;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  a_w;
    logic [NW*DW-1:0]  wd;
    logic              rsv;
    logic [AW-1:0]     a_rsv;
    logic [AW:0]       nbusy;

    logic [DW-1:0]     m_reg [NREG];
    logic [NREG-1:0]   m_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    rfile_mp #(.AW(AW), .DW(DW), .NR(NR), .NW(NW)) dut (
        .CLK   (CLK),
        .RST   (rst),
        .A_R   (a_r),
        .RD    (rd),
        .BUSY  (busy_o),
        .WE    (we),
        .A_W   (a_w),
        .WD    (wd),
        .RSV   (rsv),
        .A_RSV (a_rsv),
        .NBUSY (nbusy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREG; k++) m_reg[k] = '0;
        m_busy = '0;
    endtask

    // Expected read data from the model, following the read and forwarding rules.
    function automatic logic [DW-1:0] exp_rd(input int i);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = a_r[i*AW +: AW];
        v = (a == 0) ? '0 : m_reg[a];
`ifdef RFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (we[j] && a != 0 && a_w[j*AW +: AW] == a) v = wd[j*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int i);
        logic [AW-1:0] a;
        logic b;
        a = a_r[i*AW +: AW];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (we[j] && a != 0 && a_w[j*AW +: AW] == a) b = 1'b0;
`endif
        return b;
    endfunction

    // Apply the effect of one rising edge to the model.
    task automatic model_edge();
        logic [AW-1:0] a;
        if (rst) begin
            model_clear();
        end else begin
            for (int j = 0; j < NW; j++) begin
                a = a_w[j*AW +: AW];
                if (we[j] && a != 0) begin
                    m_reg[a]  = wd[j*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (rsv && a_rsv != 0) m_busy[a_rsv] = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we  = '0;
        rsv = 1'b0;
    endtask

    task automatic set_ar(input int p, input logic [AW-1:0] a);
        a_r[p*AW +: AW] = a;
    endtask

    task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[p]           = 1'b1;
        a_w[p*AW +: AW] = a;
        wd[p*DW +: DW]  = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    // Compare every output against the model once per cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < NR; i++) begin
                check($sformatf("rd%0d", i), 64'(rd[i*DW +: DW]), 64'(exp_rd(i)));
                check($sformatf("busy%0d", i), 64'(busy_o[i]), 64'(exp_busy(i)));
            end
            check("nbusy", 64'(nbusy), 64'($countones(m_busy)));
        end
    end

    initial begin
        logic [DW-1:0] byp_exp;
        rst = 1'b1; a_r = '0; we = '0; a_w = '0; wd = '0; rsv = 1'b0; a_rsv = '0;
        model_clear();
        chk_en = 1'b1;
        #2;
        check("reset_nbusy", 64'(nbusy), 64'd0);
        check("reset_rd0", 64'(rd[DW-1:0]), 64'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Basic write then read.
        set_w(0, 5'd3, 32'hDEADBEEF); cyc(); idle();
        set_ar(0, 5'd3); #1;
        check("wr_rd_r3", 64'(rd[DW-1:0]), 64'hDEADBEEF);

        // Writes to r0 are dropped.
        set_w(0, 5'd0, 32'hFFFFFFFF); cyc(); idle();
        set_ar(0, 5'd0); #1;
        check("r0_zero", 64'(rd[DW-1:0]), 64'd0);

        // Same-address dual write: highest port wins.
        set_w(0, 5'd7, 32'h11); set_w(1, 5'd7, 32'h22); cyc(); idle();
        set_ar(0, 5'd7); #1;
        check("dual_wr_r7", 64'(rd[DW-1:0]), 64'h22);

        // Reserve, then clear by writeback.
        rsv = 1'b1; a_rsv = 5'd9; cyc(); idle();
        set_ar(0, 5'd9); #1;
        check("rsv_busy9", 64'(busy_o[0]), 64'd1);
        check("rsv_nbusy", 64'(nbusy), 64'd1);
        set_w(0, 5'd9, 32'h99); cyc(); idle(); #1;
        check("clr_busy9", 64'(busy_o[0]), 64'd0);
        check("clr_nbusy", 64'(nbusy), 64'd0);

        // Reserve and write on the same edge: reserve wins, data still lands.
        rsv = 1'b1; a_rsv = 5'd9; set_w(1, 5'd9, 32'h77); cyc(); idle(); #1;
        check("rsvwr_data", 64'(rd[DW-1:0]), 64'h77);
        check("rsvwr_busy", 64'(busy_o[0]), 64'd1);
        check("rsvwr_nbusy", 64'(nbusy), 64'd1);

        // Same-cycle write/read of r4.
        set_w(0, 5'd4, 32'h5); cyc(); idle();
        set_w(1, 5'd4, 32'hAA); set_ar(1, 5'd4); #1;
`ifdef RFILE_BYPASS_EN
        byp_exp = 32'hAA;
`else
        byp_exp = 32'h5;
`endif
        check("bypass_same", 64'(rd[2*DW-1:DW]), 64'(byp_exp));
        cyc(); idle(); #1;
        check("bypass_next", 64'(rd[2*DW-1:DW]), 64'hAA);

        // Asynchronous reset mid-run with r5 written and busy.
        set_w(0, 5'd5, 32'h1234); rsv = 1'b1; a_rsv = 5'd5; cyc(); idle();
        set_ar(0, 5'd5); #1;
        check("pre_rst_r5", 64'(rd[DW-1:0]), 64'h1234);
        check("pre_rst_busy5", 64'(busy_o[0]), 64'd1);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        check("async_rst_rd", 64'(rd[DW-1:0]), 64'd0);
        check("async_rst_busy", 64'(busy_o[0]), 64'd0);
        check("async_rst_nbusy", 64'(nbusy), 64'd0);
        cyc();
        rst = 1'b0;

        // Fill the scoreboard.
        for (int r = 1; r < NREG; r++) begin
            rsv = 1'b1; a_rsv = AW'(r); cyc();
        end
        idle(); #1;
        check("nbusy_full", 64'(nbusy), 64'd31);
        rsv = 1'b1; a_rsv = 5'd1; cyc(); idle(); #1;
        check("nbusy_rersv", 64'(nbusy), 64'd31);

        // Randomized traffic, biased toward a few registers to force collisions.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NR; p++) set_ar(p, rand_addr());
            for (int p = 0; p < NW; p++) begin
                we[p]           = ($urandom_range(0, 1) == 1);
                a_w[p*AW +: AW] = rand_addr();
                wd[p*DW +: DW]  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) set_ar(0, a_w[AW-1:0]);
            rsv   = ($urandom_range(0, 2) == 0);
            a_rsv = rand_addr();
            cyc();
        end
        idle();
        cyc();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
